xs3_serial_adder: RTL and testbench

//  Digit-serial excess-3 adder; the stage directly downstream of the BCD->excess-3 converter.

---
 rtl/xs3_serial_adder_pkg.sv | 20 ++
 rtl/xs3_serial_adder_if.sv | 34 +++
 rtl/xs3_serial_adder_digit_add.sv | 23 ++
 rtl/xs3_serial_adder.sv | 117 +++++++++++
 tb/tb_xs3_serial_adder.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xs3_serial_adder_pkg.sv
// Shared constants, FSM state type and digit-range helper for the digit-serial
// excess-3 adder.
package xs3_serial_adder_pkg;

  localparam logic [3:0] XS3_MIN    = 4'b0011;
  localparam logic [3:0] XS3_MAX    = 4'b1100;
  localparam logic [3:0] XS3_PLUS3  = 4'b0011;
  localparam logic [3:0] XS3_MINUS3 = 4'b1101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Codes 0000..0010 and 1101..1111 carry no decimal meaning in excess-3.
  function automatic logic xs3_invalid(input logic [3:0] digit);
    return (digit < XS3_MIN) || (digit > XS3_MAX);
  endfunction

endpackage

// File: rtl/xs3_serial_adder_if.sv
// Beat-level valid/ready bundle between a digit producer, the serial adder and
// the sum consumer.
interface xs3_serial_adder_if #(
  parameter int CNT_W = 4
);

  logic             in_valid;
  logic             in_ready;
  logic             in_first;
  logic             in_last;
  logic [3:0]       a_xs3;
  logic [3:0]       b_xs3;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       sum_xs3;
  logic             out_last;
  logic             carry_out;
  logic             digit_err;
  logic             ovf_err;
  logic [CNT_W-1:0] digit_cnt;

  modport master (
    output in_valid, in_first, in_last, a_xs3, b_xs3, out_ready,
    input  in_ready, out_valid, sum_xs3, out_last, carry_out,
           digit_err, ovf_err, digit_cnt
  );

  modport slave (
    input  in_valid, in_first, in_last, a_xs3, b_xs3, out_ready,
    output in_ready, out_valid, sum_xs3, out_last, carry_out,
           digit_err, ovf_err, digit_cnt
  );

endinterface

// File: rtl/xs3_serial_adder_digit_add.sv
// Combinational single-digit excess-3 adder: binary add, then re-bias the
// result by +3 on a decimal carry or -3 otherwise.
module xs3_digit_add
  import xs3_serial_adder_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       invalid
);

  logic [4:0] raw;

  always_comb begin
    raw     = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    cout    = raw[4];
    sum     = raw[4] ? (raw[3:0] + XS3_PLUS3) : (raw[3:0] + XS3_MINUS3);
    invalid = xs3_invalid(a) | xs3_invalid(b);
  end

endmodule

// File: rtl/xs3_serial_adder.sv
// Digit-serial excess-3 adder: one XS-3 digit pair in, one XS-3 sum digit out
// per beat, LSD first, with a registered one-deep output stage.
module xs3_serial_adder
  import xs3_serial_adder_pkg::*;
#(
  parameter int MAX_DIGITS = 8,
  parameter int CNT_W      = 4
) (
  input logic              clk,
  input logic              rst,
  xs3_serial_adder_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_DIGITS);

  state_e           state_q, state_d;
  logic             carry_q, carry_d;
  logic             out_valid_q, out_valid_d;
  logic [3:0]       sum_q, sum_d;
  logic             out_last_q, out_last_d;
  logic             carry_out_q, carry_out_d;
  logic             digit_err_q, digit_err_d;
  logic             ovf_err_q, ovf_err_d;
  logic [CNT_W-1:0] digit_cnt_q, digit_cnt_d;

  logic       in_ready;
  logic       xfer;
  logic       first_beat;
  logic       cin;
  logic [3:0] add_sum;
  logic       add_cout;
  logic       add_invalid;

  // The output stage can be refilled in the same cycle it is drained.
  assign in_ready   = ~out_valid_q | bus.out_ready;
  assign xfer       = bus.in_valid & in_ready;
  assign first_beat = bus.in_first | (state_q == ST_IDLE);
  assign cin        = first_beat ? 1'b0 : carry_q;

  xs3_digit_add u_digit_add (
    .a       (bus.a_xs3),
    .b       (bus.b_xs3),
    .cin     (cin),
    .sum     (add_sum),
    .cout    (add_cout),
    .invalid (add_invalid)
  );

  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    out_last_d  = out_last_q;
    carry_out_d = carry_out_q;
    digit_err_d = digit_err_q;
    ovf_err_d   = ovf_err_q;
    digit_cnt_d = digit_cnt_q;

    if (xfer) begin
      out_valid_d = 1'b1;
      sum_d       = add_sum;
      out_last_d  = bus.in_last;
      carry_out_d = bus.in_last & add_cout;
      carry_d     = ~bus.in_last & add_cout;
      state_d     = bus.in_last ? ST_IDLE : ST_RUN;
      // A first beat starts a fresh number, discarding any partial one.
      if (first_beat) begin
        digit_cnt_d = CNT_ONE;
        digit_err_d = add_invalid;
        ovf_err_d   = 1'b0;
      end else begin
        digit_err_d = digit_err_q | add_invalid;
        ovf_err_d   = ovf_err_q | (digit_cnt_q == CNT_LIMIT);
        digit_cnt_d = (digit_cnt_q == CNT_SAT) ? digit_cnt_q : digit_cnt_q + CNT_ONE;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= 4'b0000;
      out_last_q  <= 1'b0;
      carry_out_q <= 1'b0;
      digit_err_q <= 1'b0;
      ovf_err_q   <= 1'b0;
      digit_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      out_last_q  <= out_last_d;
      carry_out_q <= carry_out_d;
      digit_err_q <= digit_err_d;
      ovf_err_q   <= ovf_err_d;
      digit_cnt_q <= digit_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.sum_xs3   = sum_q;
  assign bus.out_last  = out_last_q;
  assign bus.carry_out = carry_out_q;
  assign bus.digit_err = digit_err_q;
  assign bus.ovf_err   = ovf_err_q;
  assign bus.digit_cnt = digit_cnt_q;

endmodule

// File: tb/tb_xs3_serial_adder.sv
// Self-checking bench for xs3_serial_adder: decimal reference model with a
// per-cycle scoreboard, hand-computed directed cases and random traffic.
module tb_xs3_serial_adder;

  localparam int MAX_DIGITS = 8;
  localparam int CNT_W      = 4;
  localparam int CNT_SAT    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  xs3_serial_adder_if #(.CNT_W(CNT_W)) bus ();

  xs3_serial_adder #(
    .MAX_DIGITS (MAX_DIGITS),
    .CNT_W      (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  function automatic void cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: decimal arithmetic on the decoded digits, tracking the
  // number currently being received.
  bit         m_valid;
  bit         m_in_number;
  int         m_carry;
  bit         m_last;
  bit         m_cout;
  bit         m_derr;
  bit         m_ovf;
  logic [3:0] m_sum;
  int         m_cnt;

  function automatic void model_reset();
    m_valid     = 0;
    m_in_number = 0;
    m_carry     = 0;
    m_last      = 0;
    m_cout      = 0;
    m_derr      = 0;
    m_ovf       = 0;
    m_sum       = 4'd0;
    m_cnt       = 0;
  endfunction

  function automatic void model_beat(input int a, input int b, input bit first, input bit last);
    bit is_first;
    int cin, raw, dec_sum;
    bit carry, bad;
    is_first = first || !m_in_number;
    cin      = is_first ? 0 : m_carry;
    raw      = a + b + cin;
    dec_sum  = raw - 6;
    carry    = (raw >= 16);
    bad      = (a < 3) || (a > 12) || (b < 3) || (b > 12);
    m_sum    = 4'((dec_sum - (carry ? 10 : 0) + 3) & 15);
    if (is_first) begin
      m_cnt  = 1;
      m_derr = bad;
      m_ovf  = 0;
    end else begin
      m_ovf  = m_ovf || (m_cnt == MAX_DIGITS);
      m_cnt  = (m_cnt == CNT_SAT) ? CNT_SAT : m_cnt + 1;
      m_derr = m_derr || bad;
    end
    m_valid     = 1;
    m_last      = last;
    m_cout      = carry;
    m_carry     = last ? 0 : int'(carry);
    m_in_number = !last;
  endfunction

  // Scoreboard: compares DUT state after each rising edge, then advances the
  // model with whatever the DUT will see at the next rising edge.
  always @(negedge clk) begin
    bit exp_ready;
    if (rst) begin
      model_reset();
      cmp("sb_rst_out_valid", 8'(bus.out_valid), 8'd0);
      cmp("sb_rst_sum",       8'(bus.sum_xs3),   8'd0);
      cmp("sb_rst_last",      8'(bus.out_last),  8'd0);
      cmp("sb_rst_cout",      8'(bus.carry_out), 8'd0);
      cmp("sb_rst_derr",      8'(bus.digit_err), 8'd0);
      cmp("sb_rst_ovf",       8'(bus.ovf_err),   8'd0);
      cmp("sb_rst_cnt",       8'(bus.digit_cnt), 8'd0);
    end else begin
      cmp("sb_out_valid", 8'(bus.out_valid), 8'(m_valid));
      if (m_valid) begin
        cmp("sb_sum",  8'(bus.sum_xs3),   8'(m_sum));
        cmp("sb_last", 8'(bus.out_last),  8'(m_last));
        cmp("sb_derr", 8'(bus.digit_err), 8'(m_derr));
        cmp("sb_ovf",  8'(bus.ovf_err),   8'(m_ovf));
        cmp("sb_cnt",  8'(bus.digit_cnt), 8'(m_cnt));
        if (m_last) cmp("sb_cout", 8'(bus.carry_out), 8'(m_cout));
      end
      exp_ready = !m_valid || bus.out_ready;
      cmp("sb_in_ready", 8'(bus.in_ready), 8'(exp_ready));
      if (bus.in_valid && exp_ready)
        model_beat(int'(bus.a_xs3), int'(bus.b_xs3), bus.in_first, bus.in_last);
      else if (bus.out_ready)
        m_valid = 0;
    end
  end

  // Presents one beat and returns just after the edge that accepts it.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                               input logic first, input logic last);
    int waited;
    bit ok;
    bus.a_xs3    = a;
    bus.b_xs3    = b;
    bus.in_first = first;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    ok     = 0;
    waited = 0;
    while (!ok && waited < 50) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1;
      waited++;
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout: got in_ready=0, expected acceptance within 50 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] sum, input logic last,
                             input logic cout, input logic derr, input logic ovf,
                             input int cnt);
    cmp({name, "_valid"}, 8'(bus.out_valid), 8'd1);
    cmp({name, "_sum"},   8'(bus.sum_xs3),   8'(sum));
    cmp({name, "_last"},  8'(bus.out_last),  8'(last));
    cmp({name, "_derr"},  8'(bus.digit_err), 8'(derr));
    cmp({name, "_ovf"},   8'(bus.ovf_err),   8'(ovf));
    cmp({name, "_cnt"},   8'(bus.digit_cnt), 8'(cnt));
    if (last) cmp({name, "_cout"}, 8'(bus.carry_out), 8'(cout));
  endtask

  function automatic logic [3:0] rand_digit();
    if ($urandom_range(0, 9) == 0) return 4'($urandom_range(0, 15));
    return 4'($urandom_range(3, 12));
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit acc;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_first  = 1'b0;
    bus.in_last   = 1'b0;
    bus.a_xs3     = 4'd0;
    bus.b_xs3     = 4'd0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cmp("reset_out_valid", 8'(bus.out_valid), 8'd0);
    cmp("reset_cnt",       8'(bus.digit_cnt), 8'd0);
    cmp("reset_in_ready",  8'(bus.in_ready),  8'd1);
    rst = 1'b0;

    // 27 + 45 = 72
    applyStimulus(4'b1010, 4'b1000, 1'b1, 1'b0);
    checkOutput("add27_45_d0", 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    applyStimulus(4'b0101, 4'b0111, 1'b0, 1'b1);
    checkOutput("add27_45_d1", 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0, 2);

    // 999 + 001 = 1000
    applyStimulus(4'b1100, 4'b0100, 1'b1, 1'b0);
    checkOutput("add999_1_d0", 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    applyStimulus(4'b1100, 4'b0011, 1'b0, 1'b0);
    checkOutput("add999_1_d1", 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    applyStimulus(4'b1100, 4'b0011, 1'b0, 1'b1);
    checkOutput("add999_1_d2", 4'b0011, 1'b1, 1'b1, 1'b0, 1'b0, 3);

    // 012 + 034 = 046 with three stalled cycles mid-number
    applyStimulus(4'b0101, 4'b0111, 1'b1, 1'b0);
    checkOutput("bp_d0", 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    bus.out_ready = 1'b0;
    bus.a_xs3     = 4'b0100;
    bus.b_xs3     = 4'b0110;
    bus.in_first  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp("bp_stall_in_ready", 8'(bus.in_ready),  8'd0);
      cmp("bp_stall_sum",      8'(bus.sum_xs3),   8'b1001);
      cmp("bp_stall_valid",    8'(bus.out_valid), 8'd1);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    applyStimulus(4'b0100, 4'b0110, 1'b0, 1'b0);
    checkOutput("bp_d1", 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    applyStimulus(4'b0011, 4'b0011, 1'b0, 1'b1);
    checkOutput("bp_d2", 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0, 3);
    @(posedge clk);
    #1;
    cmp("bp_drain_valid", 8'(bus.out_valid), 8'd0);

    // Invalid digit makes digit_err sticky for that number only
    applyStimulus(4'b0000, 4'b0011, 1'b1, 1'b0);
    checkOutput("derr_d0", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    applyStimulus(4'b0100, 4'b0100, 1'b0, 1'b1);
    checkOutput("derr_d1", 4'b0101, 1'b1, 1'b0, 1'b1, 1'b0, 2);
    applyStimulus(4'b0100, 4'b0100, 1'b1, 1'b1);
    checkOutput("derr_clear", 4'b0101, 1'b1, 1'b0, 1'b0, 1'b0, 1);

    // More than MAX_DIGITS digits raises ovf_err on the ninth beat
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(4'b0011, 4'b0011, (i == 1), 1'b0);
      checkOutput($sformatf("ovf_d%0d", i), 4'b0011, 1'b0, 1'b0, 1'b0, (i == 9), i);
    end
    applyStimulus(4'b0011, 4'b0011, 1'b0, 1'b1);
    checkOutput("ovf_last", 4'b0011, 1'b1, 1'b0, 1'b0, 1'b1, 10);

    // Asynchronous reset between edges, leaving a pending carry behind
    applyStimulus(4'b1100, 4'b1100, 1'b1, 1'b0);
    checkOutput("arst_pre", 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    #1;
    rst = 1'b1;
    #1;
    cmp("arst_out_valid", 8'(bus.out_valid), 8'd0);
    cmp("arst_sum",       8'(bus.sum_xs3),   8'd0);
    cmp("arst_cnt",       8'(bus.digit_cnt), 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(4'b0011, 4'b0011, 1'b0, 1'b1);
    checkOutput("arst_idle_first", 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    applyStimulus(4'b1000, 4'b1000, 1'b1, 1'b1);
    checkOutput("arst_5p5", 4'b0011, 1'b1, 1'b1, 1'b0, 1'b0, 1);

    // in_first mid-number restarts with carry-in 0
    applyStimulus(4'b1100, 4'b1100, 1'b1, 1'b0);
    checkOutput("restart_d0", 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    applyStimulus(4'b0011, 4'b0011, 1'b1, 1'b0);
    checkOutput("restart_d1", 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    applyStimulus(4'b0011, 4'b0011, 1'b0, 1'b1);
    checkOutput("restart_d2", 4'b0011, 1'b1, 1'b0, 1'b0, 1'b0, 2);

    // Random traffic with random backpressure, checked by the scoreboard
    acc = 0;
    bus.in_valid = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!bus.in_valid || acc) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.a_xs3    = rand_digit();
        bus.b_xs3    = rand_digit();
        bus.in_first = ($urandom_range(0, 5) == 0);
        bus.in_last  = ($urandom_range(0, 4) == 0);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
